// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM data-memory SRAM controller.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
  localparam int          DEF_SRAM_AW   = 18;
  localparam int          SRAM_DW       = 16;

endpackage

// File: rtl/sram_mem_controller_phase_counter.sv
// Counts the cycles of one half-word phase; `last` marks the final cycle and
// `almost_last` the cycle before it (used to raise the write strobe early).
module phase_counter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last,
  output logic almost_last
);

  localparam int CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;

  logic [CW-1:0] cnt_r;

  // Cycle count within the current phase; clear has priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last        = (cnt_r == CW'(ACCESS_CYCLES - 1));
  assign almost_last = (cnt_r == CW'(ACCESS_CYCLES - 2));

endmodule

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM phases and stalls the
// pipeline (ready low) until the whole word has been transferred.
module sram_mem_controller
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
  parameter int          ACCESS_CYCLES = 2,
  parameter int          SRAM_AW       = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdEn,
  input  logic               wrEn,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  output logic [SRAM_AW-1:0] sramAddr,
  output logic [SRAM_DW-1:0] sramDqOut,
  input  logic [SRAM_DW-1:0] sramDqIn,
  output logic               sramDqOe,
  output logic               sramWeN
);

  state_t state_r, state_n;

  logic [SRAM_AW-1:0] addr_r, addr_n;
  logic [SRAM_DW-1:0] dq_r, dq_n;
  logic [SRAM_DW-1:0] lo_r, lo_n;
  logic [31:0]        rdata_r, rdata_n;
  logic               oe_r, oe_n;
  logic               wen_r, wen_n;
  logic               wr_op_r, wr_op_n;
  logic               ready_s;

  logic [31:0]        diff_s;
  logic [SRAM_AW-1:0] base_hw_s;
  logic               unused_s;
  logic               in_phase_s;
  logic               last_s;
  logic               almost_last_s;

  // Word offset from BASE_ADDR doubled into a half-word address; wraps silently.
  assign diff_s    = address - BASE_ADDR;
  assign base_hw_s = {diff_s[SRAM_AW:2], 1'b0};
  assign unused_s  = ^{diff_s[31:SRAM_AW+1], diff_s[1:0]};

  assign in_phase_s = (state_r == LOW) || (state_r == HIGH);

  phase_counter #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_phase_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (last_s | ~in_phase_s),
    .enable     (in_phase_s),
    .last       (last_s),
    .almost_last(almost_last_s)
  );

  // State register plus the registered SRAM-side outputs and read assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      addr_r  <= {SRAM_AW{1'b0}};
      dq_r    <= {SRAM_DW{1'b0}};
      lo_r    <= {SRAM_DW{1'b0}};
      rdata_r <= 32'd0;
      oe_r    <= 1'b0;
      wen_r   <= 1'b1;
      wr_op_r <= 1'b0;
    end else begin
      state_r <= state_n;
      addr_r  <= addr_n;
      dq_r    <= dq_n;
      lo_r    <= lo_n;
      rdata_r <= rdata_n;
      oe_r    <= oe_n;
      wen_r   <= wen_n;
      wr_op_r <= wr_op_n;
    end
  end

  // Next state and next values of the SRAM outputs (strobe high on a phase's last cycle).
  always_comb begin
    state_n = state_r;
    addr_n  = addr_r;
    dq_n    = dq_r;
    lo_n    = lo_r;
    rdata_n = rdata_r;
    oe_n    = oe_r;
    wen_n   = wen_r;
    wr_op_n = wr_op_r;
    ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = ~(rdEn | wrEn);
        if (rdEn | wrEn) begin
          state_n = LOW;
          wr_op_n = wrEn;
          addr_n  = base_hw_s;
          if (wrEn) begin
            dq_n  = writeData[15:0];
            oe_n  = 1'b1;
            wen_n = 1'b0;
          end else begin
            oe_n  = 1'b0;
            wen_n = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      LOW: begin
        if (last_s) begin
          state_n = HIGH;
          addr_n  = addr_r + SRAM_AW'(1);
          if (wr_op_r) begin
            dq_n  = writeData[31:16];
            wen_n = 1'b0;
          end else begin
            lo_n  = sramDqIn;
            wen_n = 1'b1;
          end
        end else if (almost_last_s) begin
          wen_n = 1'b1;
        end else begin
          wen_n = ~wr_op_r;
        end
      end
      HIGH: begin
        if (last_s) begin
          state_n = DONE;
          oe_n    = 1'b0;
          wen_n   = 1'b1;
          if (wr_op_r) begin
            rdata_n = rdata_r;
          end else begin
            rdata_n = {sramDqIn, lo_r};
          end
        end else if (almost_last_s) begin
          wen_n = 1'b1;
        end else begin
          wen_n = ~wr_op_r;
        end
      end
      DONE: begin
        ready_s = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        oe_n    = 1'b0;
        wen_n   = 1'b1;
      end
    endcase
  end

  assign ready     = ready_s;
  assign readData  = rdata_r;
  assign sramAddr  = addr_r;
  assign sramDqOut = dq_r;
  assign sramDqOe  = oe_r;
  assign sramWeN   = wen_r;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed self-checking bench for sram_mem_controller with a 16-bit SRAM model.
module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdEn, wrEn;
  logic [31:0] address, writeData;
  logic [31:0] readData;
  logic        ready;
  logic [17:0] sramAddr;
  logic [15:0] sramDqOut, sramDqIn;
  logic        sramDqOe, sramWeN;

  int total = 0;
  int bad   = 0;

  // SRAM model with a bench-side preload port
  logic [15:0] mem [0:262143];
  logic        pre_we = 1'b0;
  logic [17:0] pre_a  = 18'd0;
  logic [15:0] pre_d  = 16'd0;

  // capture of one access, cycles 0..6
  logic [6:0]  rdy_v, wen_v, oe_v;
  logic [17:0] addr_c [0:6];
  logic [15:0] dq_c   [0:6];
  logic [31:0] rd_c   [0:6];

  always #5 clk = ~clk;

  sram_mem_controller dut (
    .clk      (clk),
    .rst      (rst),
    .rdEn     (rdEn),
    .wrEn     (wrEn),
    .address  (address),
    .writeData(writeData),
    .readData (readData),
    .ready    (ready),
    .sramAddr (sramAddr),
    .sramDqOut(sramDqOut),
    .sramDqIn (sramDqIn),
    .sramDqOe (sramDqOe),
    .sramWeN  (sramWeN)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (!sramWeN && sramDqOe) mem[sramAddr] <= sramDqOut;
  end
  assign sramDqIn = mem[sramAddr];

  task automatic preload(input logic [17:0] a, input logic [15:0] d);
    @(negedge clk); pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk); pre_we = 1'b0;
  endtask

  // drive one request in cycle 0, hold through DONE (cycle 5), drop in cycle 6
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); rdEn = rd; wrEn = wr; address = a; writeData = d;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 6) begin rdEn = 1'b0; wrEn = 1'b0; end
      #1;
      rdy_v[c] = ready; wen_v[c] = sramWeN; oe_v[c] = sramDqOe;
      addr_c[c] = sramAddr; dq_c[c] = sramDqOut; rd_c[c] = readData;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rdEn = 1'b0; wrEn = 1'b0; address = 32'd0; writeData = 32'd0;
    #12;
    total++; if (readData !== 32'd0) begin bad++; $display("FAIL reset_readData got=%h exp=%h", readData, 32'd0); end
    total++; if (sramAddr !== 18'd0) begin bad++; $display("FAIL reset_sramAddr got=%h exp=%h", sramAddr, 18'd0); end
    total++; if (sramDqOut !== 16'd0) begin bad++; $display("FAIL reset_sramDqOut got=%h exp=%h", sramDqOut, 16'd0); end
    total++; if (sramDqOe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", sramDqOe); end
    total++; if (sramWeN !== 1'b1) begin bad++; $display("FAIL reset_wen got=%b exp=1", sramWeN); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_write;
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    total++; if (rdy_v !== 7'b1100000) begin bad++; $display("FAIL write_ready got=%b exp=%b", rdy_v, 7'b1100000); end
    total++; if (wen_v !== 7'b1110101) begin bad++; $display("FAIL write_wen got=%b exp=%b", wen_v, 7'b1110101); end
    total++; if (oe_v !== 7'b0011110) begin bad++; $display("FAIL write_oe got=%b exp=%b", oe_v, 7'b0011110); end
    total++; if ({addr_c[1], addr_c[2], addr_c[3], addr_c[4]} !== {18'd0, 18'd0, 18'd1, 18'd1})
      begin bad++; $display("FAIL write_addr got=%h %h %h %h exp=0 0 1 1", addr_c[1], addr_c[2], addr_c[3], addr_c[4]); end
    total++; if ({dq_c[1], dq_c[3]} !== {16'hBEEF, 16'hDEAD})
      begin bad++; $display("FAIL write_dq got=%h %h exp=beef dead", dq_c[1], dq_c[3]); end
    total++; if ({mem[0], mem[1]} !== {16'hBEEF, 16'hDEAD})
      begin bad++; $display("FAIL write_mem got=%h %h exp=beef dead", mem[0], mem[1]); end
    total++; if (rd_c[6] !== 32'd0) begin bad++; $display("FAIL write_readData got=%h exp=0", rd_c[6]); end
  endtask

  task automatic test_read;
    run_access(1'b1, 1'b0, 32'd1024, 32'd0);
    total++; if (rd_c[4] !== 32'd0) begin bad++; $display("FAIL read_early got=%h exp=0", rd_c[4]); end
    total++; if (rd_c[5] !== 32'hDEADBEEF) begin bad++; $display("FAIL read_done got=%h exp=deadbeef", rd_c[5]); end
    total++; if (rd_c[6] !== 32'hDEADBEEF) begin bad++; $display("FAIL read_hold got=%h exp=deadbeef", rd_c[6]); end
    total++; if (wen_v !== 7'b1111111 || oe_v !== 7'b0000000)
      begin bad++; $display("FAIL read_bus got wen=%b oe=%b exp wen=1111111 oe=0000000", wen_v, oe_v); end
    total++; if (rdy_v !== 7'b1100000) begin bad++; $display("FAIL read_ready got=%b exp=%b", rdy_v, 7'b1100000); end
  endtask

  task automatic test_addr_map;
    preload(18'd4, 16'h1111); preload(18'd5, 16'h2222);
    preload(18'h3FFFE, 16'hAAAA); preload(18'h3FFFF, 16'h5555);
    run_access(1'b1, 1'b0, 32'd1032, 32'd0);
    total++; if ({addr_c[1], addr_c[2], addr_c[3], addr_c[4]} !== {18'd4, 18'd4, 18'd5, 18'd5})
      begin bad++; $display("FAIL map_1032 got=%h %h %h %h exp=4 4 5 5", addr_c[1], addr_c[2], addr_c[3], addr_c[4]); end
    total++; if (rd_c[5] !== 32'h22221111) begin bad++; $display("FAIL map_1032_data got=%h exp=22221111", rd_c[5]); end
    run_access(1'b1, 1'b0, 32'd1020, 32'd0);
    total++; if ({addr_c[1], addr_c[3]} !== {18'h3FFFE, 18'h3FFFF})
      begin bad++; $display("FAIL map_wrap got=%h %h exp=3fffe 3ffff", addr_c[1], addr_c[3]); end
    total++; if (rd_c[5] !== 32'h5555AAAA) begin bad++; $display("FAIL map_wrap_data got=%h exp=5555aaaa", rd_c[5]); end
  endtask

  task automatic test_simultaneous;
    run_access(1'b1, 1'b1, 32'd1028, 32'h12345678);
    total++; if ({mem[2], mem[3]} !== {16'h5678, 16'h1234})
      begin bad++; $display("FAIL simul_mem got=%h %h exp=5678 1234", mem[2], mem[3]); end
    total++; if (rd_c[6] !== 32'h5555AAAA) begin bad++; $display("FAIL simul_readData got=%h exp=5555aaaa", rd_c[6]); end
    total++; if (oe_v !== 7'b0011110) begin bad++; $display("FAIL simul_oe got=%b exp=%b", oe_v, 7'b0011110); end
  endtask

  task automatic test_back_to_back;
    int phase = 0, stall = 0, wen_low = 0, cycles = 0;
    bit done = 1'b0, switch_pending = 1'b0;
    logic [31:0] got = 32'd0;
    @(negedge clk); rdEn = 1'b0; wrEn = 1'b1; address = 32'd1036; writeData = 32'hCAFEF00D;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (switch_pending) begin rdEn = 1'b1; wrEn = 1'b0; switch_pending = 1'b0; end
      #1;
      cycles++;
      if (!sramWeN) wen_low++;
      if (!ready) stall++;
      else if (phase == 0) begin phase = 1; switch_pending = 1'b1; end
      else begin got = readData; done = 1'b1; end
    end
    rdEn = 1'b0; wrEn = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL b2b_timeout got=not_done exp=done"); end
    total++; if (wen_low !== 2) begin bad++; $display("FAIL b2b_wen_cycles got=%0d exp=2", wen_low); end
    total++; if (stall !== 10 || cycles !== 12)
      begin bad++; $display("FAIL b2b_stall got stall=%0d cycles=%0d exp stall=10 cycles=12", stall, cycles); end
    total++; if (got !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_load got=%h exp=cafef00d", got); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); rdEn = 1'b0; wrEn = 1'b1; address = 32'd1024; writeData = 32'h0BADCAFE;
    repeat (4) @(negedge clk);
    #1;
    total++; if (dut.state_r !== arm_mem_pkg::HIGH) begin bad++; $display("FAIL rmid_pre_state got=%0d exp=%0d", dut.state_r, arm_mem_pkg::HIGH); end
    rst = 1'b1; #1;
    total++; if (sramWeN !== 1'b1) begin bad++; $display("FAIL rmid_wen got=%b exp=1", sramWeN); end
    total++; if (sramDqOe !== 1'b0) begin bad++; $display("FAIL rmid_oe got=%b exp=0", sramDqOe); end
    total++; if (dut.state_r !== arm_mem_pkg::IDLE) begin bad++; $display("FAIL rmid_state got=%0d exp=%0d", dut.state_r, arm_mem_pkg::IDLE); end
    @(negedge clk); wrEn = 1'b0; rst = 1'b0; #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", ready); end
    total++; if (readData !== 32'd0 || sramAddr !== 18'd0)
      begin bad++; $display("FAIL rmid_regs got rd=%h addr=%h exp rd=0 addr=0", readData, sramAddr); end
    total++; if ({mem[0], mem[1]} !== {16'hCAFE, 16'h0BAD})
      begin bad++; $display("FAIL rmid_mem got=%h %h exp=cafe 0bad", mem[0], mem[1]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_map();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_mem_controller.md
# sram_mem_controller

Sequences every data-memory access issued by the ARM pipeline's MEM stage onto an external 16-bit asynchronous SRAM. It splits each 32-bit LDR/STR word into two 16-bit half-word phases and holds `ready` low for the whole access. The hazard/freeze logic uses `~ready` to stall every pipeline stage. It sits between the MEM-stage register (which supplies the `memRead`/`memWrite` decoded by the control unit) and the SRAM pins.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address mapped to SRAM half-word 0.
- `ACCESS_CYCLES`, 2: cycles per half-word phase; legal minimum 2.
- `SRAM_AW`, 18: SRAM address width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rdEn`  in  1  read request (LDR), held stable by the stalled pipeline.
- `wrEn`  in  1  write request (STR), held stable by the stalled pipeline.
- `address`  in  32  byte address; word aligned.
- `writeData`  in  32  store data.
- `readData`  out  32  load data.
- `ready`  out  1  pipeline may advance; 0 freezes the pipeline.
- `sramAddr`  out  SRAM_AW  half-word address.
- `sramDqOut`  out  16  write data driven onto the SRAM bus.
- `sramDqIn`  in  16  read data from the SRAM bus.
- `sramDqOe`  out  1  drive enable for `sramDqOut`.
- `sramWeN`  out  1  active-low write strobe.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - `ready = ~(rdEn | wrEn)` (combinational).
  - Any request moves the FSM to LOW and latches the operation.
  - If `rdEn` and `wrEn` are both 1, the operation is a write.
- LOW: runs `ACCESS_CYCLES` cycles, then moves to HIGH.
  - `sramAddr = ((address - BASE_ADDR) >> 2) << 1`.
  - On a write, `sramDqOut = writeData[15:0]`.
- HIGH: same as LOW, with `sramAddr` + 1 and `writeData[31:16]`. Runs `ACCESS_CYCLES` cycles, then moves to DONE.
- DONE:
  - `ready = 1` for exactly one cycle, then unconditionally to IDLE.
  - The request still asserted in this cycle is the completed one and is not restarted.
- Write phases:
  - `sramDqOe = 1` for the whole phase.
  - `sramWeN = 0` on every phase cycle except the last, so the address and data change only while `sramWeN = 1`.
- Read phases:
  - `sramDqOe = 0` and `sramWeN = 1`.
  - `sramDqIn` is sampled on the last cycle of LOW into bits [15:0] and on the last cycle of HIGH into bits [31:16].
  - `readData` updates on entry to DONE and holds until the next read completes. Writes do not change `readData`.
- Address arithmetic: 32-bit unsigned subtraction, truncated to `SRAM_AW` bits. Addresses below `BASE_ADDR` wrap; this is not flagged.
- Phase counter: counts 0..`ACCESS_CYCLES`-1 and clears on every phase change.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `readData = 0`, `sramAddr = 0`, `sramDqOut = 0`.
  - `sramDqOe = 0`, `sramWeN = 1`.
  - `ready` follows the IDLE equation.
- Latency:
  - The request is seen in IDLE at cycle 0. LOW spans cycles 1..N, HIGH spans N+1..2N, and DONE is cycle 2N+1, where N = `ACCESS_CYCLES`.
  - `ready` is low in cycles 0..2N and high in cycle 2N+1. For N=2, the stall is 5 cycles.
- Back-to-back requests: the earliest next acceptance is in IDLE at cycle 2N+2.
- Reset asserted mid-access: immediately returns to IDLE and releases the bus (`sramDqOe = 0`, `sramWeN = 1`). A partially written word is not rolled back.
- `rdEn`/`wrEn` changing during LOW or HIGH is ignored; only the latched operation completes.

## Structure
- Package `arm_mem_pkg`:
  - state enum.
  - `BASE_ADDR` default.
  - `SRAM_AW` and `SRAM_DW = 16` constants.
- Sub-module `phase_counter`: parameterised by `ACCESS_CYCLES`; inputs clear/enable, output `last`.
- Everything else lives in one FSM module.

## Test plan
- Write: `wrEn = 1`, `address = 1024`, `writeData = 0xDEADBEEF`, N=2.
  - SRAM[0] = 0xBEEF and SRAM[1] = 0xDEAD.
  - `ready` is low for 5 cycles, then high for 1.
  - `sramWeN` is low in the first cycle of each phase only.
- Read: `rdEn = 1`, `address = 1024`, SRAM model preloaded as in the write test. `readData = 0xDEADBEEF` in the DONE cycle and held afterwards.
- Address mapping: `address = 1032` → `sramAddr` is 4 then 5. `address = 1020` → wraps to 0x3FFFE then 0x3FFFF.
- Simultaneous requests: `rdEn = wrEn = 1`, `writeData = 0x12345678` → write performed and `readData` unchanged.
- Back-to-back: a STR then an LDR to the same address, with requests held until `ready` → exactly two accesses, no restart in DONE, LDR returns the stored value.
- Reset: `rst` pulsed in the second HIGH cycle of a write.
  - Same cycle: `sramWeN = 1`, `sramDqOe = 0`, state IDLE.
  - After `rst` deasserts: `ready = 1` with no request pending.
